// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: size codes, FSM states, lane and extend helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dmem_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_e;

    // Bits [7:4] of the result land in the next word; a nonzero upper nibble means a split access.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [1:0] size,
                                                input logic uns);
        logic [31:0] r;
        case (size)
            SZ_B:    r = uns ? {24'd0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            SZ_H:    r = uns ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bytelane_if.sv
// Request/response bundle between a load/store unit and dmem_bytelane.
// Latency: n/a. Backpressure: req_valid/req_ready on requests; responses are never stalled.
interface dmem_bytelane_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_ram.sv
// Single-port DEPTH x 32 synchronous RAM with per-byte write enables, no reset on contents.
// Latency: read data registered, valid the cycle after the address edge (read-before-write).
// Backpressure: none; one access per cycle.
module dmem_lane_ram #(
    parameter int DEPTH = 65536,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_we,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (i_we[l]) begin
                r_mem[i_addr][8*l +: 8] <= i_wdata[8*l +: 8];
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_bytelane.sv
// Byte/half/word data memory with sign/zero-extending loads; DMEM_MISALIGN_EN splits cross-word accesses.
// Latency: 1 cycle for in-word and error responses, 2 cycles for split accesses.
// Backpressure: req_ready low only in SECOND; responses are a single unstallable pulse.
module dmem_bytelane #(
    parameter int DEPTH  = 65536,
    parameter int ADDR_W = 32
) (
    input logic             clk,
    input logic             rst,
    dmem_bytelane_if.slave  bus
);
    import dmem_pkg::*;

    localparam int IW  = $clog2(DEPTH);
    localparam int WAW = ADDR_W - 1;
    localparam logic [WAW-1:0] LP_DEPTH = WAW'(DEPTH);

    logic [WAW-1:0] w_waddr0;
    logic [7:0]     w_mask;
    logic           w_cross;
    logic           w_err;
    logic           w_ready;
    logic           w_accept;
    logic           w_fin;
    logic [4:0]     w_sh;
    logic [31:0]    w_wdata_lo;
    logic [63:0]    w_pair;
    logic [31:0]    w_rot;
    logic [IW-1:0]  w_ram_addr;
    logic [3:0]     w_ram_we;
    logic [31:0]    w_ram_wdata;
    logic [31:0]    w_ram_rdata;

    logic           r_rsp_vld;
    logic           r_rsp_err;
    logic           r_rsp_load;
    logic [1:0]     r_rsp_size;
    logic           r_rsp_uns;
    logic [1:0]     r_rsp_off;

    // Extra top bit keeps word+1 from wrapping back into range.
    assign w_waddr0   = {1'b0, bus.req_addr[ADDR_W-1:2]};
    assign w_mask     = lane_mask(bus.req_size, bus.req_addr[1:0]);
    assign w_cross    = |w_mask[7:4];
    assign w_sh       = {bus.req_addr[1:0], 3'b000};
    assign w_wdata_lo = bus.req_wdata << w_sh;
    assign w_accept   = bus.req_valid & w_ready;

`ifdef DMEM_MISALIGN_EN
    logic [WAW-1:0] w_waddr1;
    logic [31:0]    w_wdata_hi;
    state_e         r_state;
    state_e         w_state_nx;
    logic [IW-1:0]  r_waddr1;
    logic           r_we;
    logic [3:0]     r_mask_hi;
    logic [31:0]    r_wdata_hi;
    logic [31:0]    r_word0;
    logic           r_rsp_cross;

    assign w_waddr1   = w_waddr0 + WAW'(1);
    assign w_wdata_hi = (w_sh == 5'd0) ? 32'd0 : (bus.req_wdata >> (6'd32 - {1'b0, w_sh}));
    assign w_err      = (bus.req_size == SZ_RSV) || (w_waddr0 >= LP_DEPTH) ||
                        (w_cross && (w_waddr1 >= LP_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_cross && !w_err) w_state_nx = SECOND;
            SECOND:  w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        w_ready     = (r_state == IDLE);
        w_fin       = (r_state == SECOND);
        w_ram_addr  = w_waddr0[IW-1:0];
        w_ram_we    = (w_accept && bus.req_we && !w_err) ? w_mask[3:0] : 4'd0;
        w_ram_wdata = w_wdata_lo;
        if (r_state == SECOND) begin
            w_ram_addr  = r_waddr1;
            w_ram_we    = r_we ? r_mask_hi : 4'd0;
            w_ram_wdata = r_wdata_hi;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waddr1    <= '0;
            r_we        <= 1'b0;
            r_mask_hi   <= 4'd0;
            r_wdata_hi  <= 32'd0;
            r_rsp_cross <= 1'b0;
            r_word0     <= 32'd0;
        end else begin
            if (w_accept) begin
                r_waddr1    <= w_waddr1[IW-1:0];
                r_we        <= bus.req_we;
                r_mask_hi   <= w_mask[7:4];
                r_wdata_hi  <= w_wdata_hi;
                r_rsp_cross <= w_cross & ~w_err;
            end
            // The RAM output still holds word0 during SECOND; keep it before word1 replaces it.
            if (r_state == SECOND) begin
                r_word0 <= w_ram_rdata;
            end
        end
    end

    assign w_pair = r_rsp_cross ? {w_ram_rdata, r_word0} : {32'd0, w_ram_rdata};
`else
    assign w_err   = (bus.req_size == SZ_RSV) || (w_waddr0 >= LP_DEPTH) || w_cross;
    assign w_ready = 1'b1;
    assign w_fin   = 1'b0;

    always_comb begin
        w_ram_addr  = w_waddr0[IW-1:0];
        w_ram_we    = (w_accept && bus.req_we && !w_err) ? w_mask[3:0] : 4'd0;
        w_ram_wdata = w_wdata_lo;
    end

    assign w_pair = {32'd0, w_ram_rdata};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_vld  <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_rsp_load <= 1'b0;
            r_rsp_size <= SZ_B;
            r_rsp_uns  <= 1'b0;
            r_rsp_off  <= 2'd0;
        end else begin
            r_rsp_vld <= w_fin;
            r_rsp_err <= 1'b0;
            if (w_accept) begin
                r_rsp_load <= ~bus.req_we & ~w_err;
                r_rsp_size <= bus.req_size;
                r_rsp_uns  <= bus.req_unsigned;
                r_rsp_off  <= bus.req_addr[1:0];
                if (!w_cross || w_err) begin
                    r_rsp_vld <= 1'b1;
                    r_rsp_err <= w_err;
                end
            end
        end
    end

    dmem_lane_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign w_rot         = 32'(w_pair >> {r_rsp_off, 3'b000});
    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_vld;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = (r_rsp_vld && r_rsp_load) ? load_extend(w_rot, r_rsp_size, r_rsp_uns) : 32'd0;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed bench for dmem_bytelane; exercises the DMEM_MISALIGN_EN split path when that macro is defined.
module tb_dmem_bytelane;
    localparam int DEPTH = 65536;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    int          lat;
    int          rlow;
    logic [31:0] rd;
    logic        er;

    dmem_bytelane_if #(.ADDR_W(32)) bus ();

    dmem_bytelane #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Drives one request, then records latency to rsp_valid (0 = none within bound) and req_ready-low cycles.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        int w;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        lat  = 0;
        rlow = 0;
        rd   = 32'hxxxxxxxx;
        er   = 1'bx;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (bus.rsp_valid === 1'b1) begin
                lat = i;
                rd  = bus.rsp_rdata;
                er  = bus.rsp_err;
                break;
            end
            if (bus.req_ready !== 1'b1) rlow++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_vld_in_rst: got %b want 0", bus.rsp_valid);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_vld_err: got %b/%b want 0/0", bus.rsp_valid, bus.rsp_err);
        end
        n_cmp++;
        if (bus.rsp_rdata !== 32'd0) begin
            n_bad++; $display("FAIL reset_rdata: got %h want 00000000", bus.rsp_rdata);
        end
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready: got %b want 1", bus.req_ready);
        end
    endtask

    task automatic test_word;
        issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        n_cmp++;
        if (lat !== 1 || er !== 1'b0 || rd !== 32'd0) begin
            n_bad++; $display("FAIL sw_100: lat=%0d err=%b rdata=%h want 1/0/00000000", lat, er, rd);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
        n_cmp++;
        if (lat !== 1 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL lw_100: lat=%0d err=%b rdata=%h want 1/0/deadbeef", lat, er, rd);
        end
    endtask

    task automatic test_subword;
        issue(1'b1, 2'b00, 1'b0, 32'h102, 32'hAAAAAA55);
        n_cmp++;
        if (lat !== 1 || er !== 1'b0) begin
            n_bad++; $display("FAIL sb_102: lat=%0d err=%b want 1/0", lat, er);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
        n_cmp++;
        if (rd !== 32'hDE55BEEF || er !== 1'b0) begin
            n_bad++; $display("FAIL lw_after_sb: rdata=%h err=%b want de55beef/0", rd, er);
        end
        issue(1'b0, 2'b00, 1'b0, 32'h103, 32'd0);
        n_cmp++;
        if (rd !== 32'hFFFFFFDE || lat !== 1) begin
            n_bad++; $display("FAIL lb_103: rdata=%h lat=%0d want ffffffde/1", rd, lat);
        end
        issue(1'b0, 2'b00, 1'b1, 32'h103, 32'd0);
        n_cmp++;
        if (rd !== 32'h000000DE) begin
            n_bad++; $display("FAIL lbu_103: rdata=%h want 000000de", rd);
        end
        issue(1'b0, 2'b01, 1'b0, 32'h102, 32'd0);
        n_cmp++;
        if (rd !== 32'hFFFFDE55) begin
            n_bad++; $display("FAIL lh_102: rdata=%h want ffffde55", rd);
        end
        issue(1'b0, 2'b01, 1'b0, 32'h101, 32'd0);
        n_cmp++;
        if (lat !== 1 || er !== 1'b0 || rd !== 32'h000055BE) begin
            n_bad++; $display("FAIL lh_101_inword: lat=%0d err=%b rdata=%h want 1/0/000055be", lat, er, rd);
        end
    endtask

    task automatic test_cross;
        issue(1'b1, 2'b10, 1'b0, 32'h104, 32'hA5A5A5A5);
        issue(1'b1, 2'b10, 1'b0, 32'h108, 32'h5A5A5A5A);
`ifdef DMEM_MISALIGN_EN
        issue(1'b1, 2'b10, 1'b0, 32'h106, 32'h11223344);
        n_cmp++;
        if (lat !== 2 || rlow !== 1 || er !== 1'b0 || rd !== 32'd0) begin
            n_bad++; $display("FAIL sw_106_split: lat=%0d rdy_low=%0d err=%b rdata=%h want 2/1/0/0", lat, rlow, er, rd);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h106, 32'd0);
        n_cmp++;
        if (lat !== 2 || rlow !== 1 || er !== 1'b0 || rd !== 32'h11223344) begin
            n_bad++; $display("FAIL lw_106_split: lat=%0d rdy_low=%0d err=%b rdata=%h want 2/1/0/11223344", lat, rlow, er, rd);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h104, 32'd0);
        n_cmp++;
        if (rd !== 32'h3344A5A5) begin
            n_bad++; $display("FAIL lw_104_lanes: rdata=%h want 3344a5a5", rd);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h108, 32'd0);
        n_cmp++;
        if (rd !== 32'h5A5A1122) begin
            n_bad++; $display("FAIL lw_108_lanes: rdata=%h want 5a5a1122", rd);
        end
        issue(1'b0, 2'b01, 1'b0, 32'h103, 32'd0);
        n_cmp++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'hFFFFA5DE) begin
            n_bad++; $display("FAIL lh_103_split: lat=%0d err=%b rdata=%h want 2/0/ffffa5de", lat, er, rd);
        end
`else
        issue(1'b0, 2'b10, 1'b0, 32'h106, 32'd0);
        n_cmp++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'd0) begin
            n_bad++; $display("FAIL lw_106_cross_err: lat=%0d err=%b rdata=%h want 1/1/0", lat, er, rd);
        end
        issue(1'b1, 2'b10, 1'b0, 32'h106, 32'h11223344);
        n_cmp++;
        if (lat !== 1 || er !== 1'b1) begin
            n_bad++; $display("FAIL sw_106_cross_err: lat=%0d err=%b want 1/1", lat, er);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h104, 32'd0);
        n_cmp++;
        if (rd !== 32'hA5A5A5A5) begin
            n_bad++; $display("FAIL lw_104_untouched: rdata=%h want a5a5a5a5", rd);
        end
        issue(1'b0, 2'b01, 1'b0, 32'h103, 32'd0);
        n_cmp++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            n_bad++; $display("FAIL lh_103_cross_err: err=%b rdata=%h want 1/0", er, rd);
        end
`endif
    endtask

    task automatic test_errors;
        issue(1'b1, 2'b10, 1'b0, 32'h0, 32'h12345678);
        issue(1'b0, 2'b11, 1'b0, 32'h0, 32'd0);
        n_cmp++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'd0) begin
            n_bad++; $display("FAIL rsv_load: lat=%0d err=%b rdata=%h want 1/1/0", lat, er, rd);
        end
        issue(1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFFFFFF);
        n_cmp++;
        if (er !== 1'b1) begin
            n_bad++; $display("FAIL rsv_store: err=%b want 1", er);
        end
        issue(1'b1, 2'b10, 1'b0, DEPTH * 4, 32'hFFFFFFFF);
        n_cmp++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'd0) begin
            n_bad++; $display("FAIL sw_depth: lat=%0d err=%b rdata=%h want 1/1/0", lat, er, rd);
        end
        issue(1'b1, 2'b10, 1'b0, 32'h80000000, 32'hEEEEEEEE);
        n_cmp++;
        if (er !== 1'b1) begin
            n_bad++; $display("FAIL sw_high_bits: err=%b want 1", er);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h0, 32'd0);
        n_cmp++;
        if (er !== 1'b0 || rd !== 32'h12345678) begin
            n_bad++; $display("FAIL lw_0_unchanged: err=%b rdata=%h want 0/12345678", er, rd);
        end
        issue(1'b1, 2'b10, 1'b0, DEPTH * 4 - 4, 32'hAABBCCDD);
        issue(1'b1, 2'b01, 1'b0, DEPTH * 4 - 1, 32'h00001111);
        n_cmp++;
        if (lat !== 1 || er !== 1'b1) begin
            n_bad++; $display("FAIL sh_last_cross: lat=%0d err=%b want 1/1", lat, er);
        end
        issue(1'b0, 2'b10, 1'b0, DEPTH * 4 - 4, 32'd0);
        n_cmp++;
        if (er !== 1'b0 || rd !== 32'hAABBCCDD) begin
            n_bad++; $display("FAIL lw_last_word: err=%b rdata=%h want 0/aabbccdd", er, rd);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h200;
        bus.req_wdata    = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        bus.req_we   = 1'b0;
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_store_rsp: vld=%b err=%b rdy=%b want 1/0/1", bus.rsp_valid, bus.rsp_err, bus.req_ready);
        end
        @(posedge clk);
        #1;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b1;
        bus.req_addr     = 32'h201;
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hCAFEF00D) begin
            n_bad++; $display("FAIL b2b_lw: vld=%b rdata=%h want 1/cafef00d", bus.rsp_valid, bus.rsp_rdata);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h000000F0) begin
            n_bad++; $display("FAIL b2b_lbu: vld=%b rdata=%h want 1/000000f0", bus.rsp_valid, bus.rsp_rdata);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_idle: vld=%b want 0", bus.rsp_valid);
        end
    endtask

`ifdef DMEM_MISALIGN_EN
    task automatic test_reset_second;
        issue(1'b1, 2'b10, 1'b0, 32'h208, 32'd0);
        issue(1'b1, 2'b10, 1'b0, 32'h20C, 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h20A;
        bus.req_wdata = 32'h99887766;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin
            n_bad++; $display("FAIL rst2_in_second: rdy=%b want 0", bus.req_ready);
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'd0 || bus.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst2_async: vld=%b err=%b rdata=%h rdy=%b want 0/0/0/1", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_ready);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst2_no_rsp: vld=%b want 0", bus.rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst2_release: vld=%b rdy=%b want 0/1", bus.rsp_valid, bus.req_ready);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h20C, 32'd0);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_bad++; $display("FAIL rst2_word1: rdata=%h want 00000000", rd);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h208, 32'd0);
        n_cmp++;
        if (rd !== 32'h77660000) begin
            n_bad++; $display("FAIL rst2_word0: rdata=%h want 77660000", rd);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_cross();
        test_errors();
        test_back_to_back();
`ifdef DMEM_MISALIGN_EN
        test_reset_second();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
